// File: rtl/design1_wrapper.sv
// Bitcoin block hash: SHA-256(SHA-256(header)) of one 80-byte header over AXI-Stream.
// Optional macro AXIS_OUT_TLAST_EN adds m_axis_tlast on the last digest word.
module design1_wrapper #(
  parameter int C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
`ifdef AXIS_OUT_TLAST_EN
  ,
  output logic                          m_axis_tlast
`endif
);

  if (C_AXIS_TDATA_WIDTH != 32) begin : g_bad_width
    $error("design1_wrapper supports only C_AXIS_TDATA_WIDTH = 32");
  end

  typedef enum logic [2:0] {RECV, HASH1, HASH2, HASH3, SEND} state_t;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  state_t      state, state_nx;
  logic        rdy_q;
  logic [4:0]  cnt;
  logic [6:0]  rnd;
  logic [2:0]  oc;
  logic [31:0] hdr [20];
  logic [31:0] hv  [8];
  logic [31:0] st  [8];
  logic [31:0] w   [16];
  logic [5:0]  kidx;
  logic [31:0] t1, t2, wnew;
  logic        s_hs, m_hs;

  assign s_axis_tready = (state == RECV) && rdy_q;
  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = m_axis_tvalid ? bswap(hv[oc]) : '0;
`ifdef AXIS_OUT_TLAST_EN
  assign m_axis_tlast  = m_axis_tvalid && (oc == 3'd7);
`endif

  assign s_hs = s_axis_tvalid && s_axis_tready;
  assign m_hs = m_axis_tvalid && m_axis_tready;
  // rnd 1..64 maps to K[0..63]; rnd 64 wraps to index 63 in 6 bits
  assign kidx = rnd[5:0] - 6'd1;

  always_comb begin
    t1   = st[7] + bsig1(st[4]) + ((st[4] & st[5]) ^ (~st[4] & st[6])) + K[kidx] + w[0];
    t2   = bsig0(st[0]) + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
    wnew = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= RECV;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RECV:    if (s_hs && cnt == 5'd19) state_nx = HASH1;
      HASH1:   if (rnd == 7'd65) state_nx = HASH2;
      HASH2:   if (rnd == 7'd65) state_nx = HASH3;
      HASH3:   if (rnd == 7'd65) state_nx = SEND;
      SEND:    if (m_hs && oc == 3'd7) state_nx = RECV;
      default: state_nx = RECV;
    endcase
  end

  // Each compression: rnd 0 loads, rnd 1..64 are rounds, rnd 65 adds into hv.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q <= 1'b0;
      cnt   <= '0;
      rnd   <= '0;
      oc    <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        hv[i] <= '0;
        st[i] <= '0;
      end
      for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
      for (int unsigned i = 0; i < 20; i++) hdr[i] <= '0;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        RECV: if (s_hs) begin
          hdr[cnt] <= bswap(s_axis_tdata);
          cnt      <= (cnt == 5'd19) ? '0 : cnt + 5'd1;
        end
        HASH1, HASH2, HASH3: begin
          rnd <= (rnd == 7'd65) ? '0 : rnd + 7'd1;
          if (rnd == 7'd0) begin
            for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
            if (state == HASH1) begin
              for (int unsigned i = 0; i < 16; i++) w[i] <= hdr[i];
              for (int unsigned i = 0; i < 8; i++) begin
                hv[i] <= IV[i];
                st[i] <= IV[i];
              end
            end else if (state == HASH2) begin
              for (int unsigned i = 0; i < 4; i++) w[i] <= hdr[16+i];
              w[4]  <= 32'h80000000;
              w[15] <= 32'd640;
              for (int unsigned i = 0; i < 8; i++) st[i] <= hv[i];
            end else begin
              for (int unsigned i = 0; i < 8; i++) begin
                w[i]  <= hv[i];
                hv[i] <= IV[i];
                st[i] <= IV[i];
              end
              w[8]  <= 32'h80000000;
              w[15] <= 32'd256;
            end
          end else if (rnd == 7'd65) begin
            for (int unsigned i = 0; i < 8; i++) hv[i] <= hv[i] + st[i];
          end else begin
            st[0] <= t1 + t2;
            st[1] <= st[0];
            st[2] <= st[1];
            st[3] <= st[2];
            st[4] <= st[3] + t1;
            st[5] <= st[4];
            st[6] <= st[5];
            st[7] <= st[6];
            for (int unsigned i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= wnew;
          end
        end
        SEND: if (m_hs) oc <= (oc == 3'd7) ? '0 : oc + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_design1_wrapper.sv
// Self-checking bench for design1_wrapper: genesis digest, stalls, back-to-back, resets, latency.
module tb_design1_wrapper;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
`ifdef AXIS_OUT_TLAST_EN
  logic        m_axis_tlast;
`endif

  design1_wrapper #(.C_AXIS_TDATA_WIDTH(32)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef AXIS_OUT_TLAST_EN
    ,
    .m_axis_tlast  (m_axis_tlast)
`endif
  );

  always #5 aclk = ~aclk;

  int unsigned cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [31:0] gen_hdr [20] = '{
    32'h00000001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'hFDEDA33B, 32'hB2127B7A, 32'h3E2CC77A, 32'h618F7667,
    32'hC31BC87F, 32'h32518A88, 32'hAAB89F3A, 32'h4A5E1E4B,
    32'h495FAB29, 32'h1D00FFFF, 32'h7C2BAC1D};
  logic [31:0] gen_dig [8] = '{
    32'h0A8CE26F, 32'h72B3F1B6, 32'h46A2A6C1, 32'h4FF763AE,
    32'h65831E93, 32'h9C085AE1, 32'h0019D668, 32'h00000000};

  logic [31:0] q [$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned t_hs = 0;
  int unsigned lat_gen = 0;
  int unsigned lat_zero = 0;
  int unsigned lat_tmp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives nwords header words; a completed 20-word genesis header queues its digest.
  task automatic send_header(input bit zero, input bit gaps, input int unsigned nwords);
    int unsigned idx = 0;
    int unsigned guard = 0;
    while (idx < nwords && guard < 500) begin
      @(negedge aclk);
      guard++;
      if (gaps && (cyc % 5 == 2)) s_axis_tvalid = 1'b0;
      else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = zero ? 32'h0 : gen_hdr[idx];
      end
      if (s_axis_tvalid && s_axis_tready) begin
        idx++;
        t_hs = cyc + 1;
      end
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    check("send_words", idx, nwords);
    if (nwords == 20 && !zero)
      for (int i = 0; i < 8; i++) q.push_back(gen_dig[i]);
  endtask

  task automatic recv_digest(input bit stall, input bit check_data, output int unsigned lat);
    int unsigned k = 0;
    int unsigned guard = 0;
    bit first = 1'b1;
    bit rdy_hi = 1'b0;
    logic [31:0] e;
    lat = 0;
    while (k < 8 && guard < 3000) begin
      @(negedge aclk);
      guard++;
      m_axis_tready = stall ? ((cyc % 8) >= 2) : 1'b1;
      if (s_axis_tready) rdy_hi = 1'b1;
      if (m_axis_tvalid) begin
        if (first) begin
          lat   = cyc - t_hs;
          first = 1'b0;
        end
        if (check_data) begin
          e = (q.size() > 0) ? q[0] : 32'hDEADBEEF;
          check("digest_word", m_axis_tdata, e);
        end
`ifdef AXIS_OUT_TLAST_EN
        check("tlast", m_axis_tlast, (k == 7));
`endif
        if (m_axis_tready) begin
          k++;
          if (check_data && q.size() > 0) void'(q.pop_front());
        end
      end
    end
    check("recv_words", k, 8);
    check("tready_low_busy", rdy_hi, 1'b0);
  endtask

  task automatic do_reset();
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tdata", m_axis_tdata, 32'h0);
`ifdef AXIS_OUT_TLAST_EN
    check("rst_m_tlast", m_axis_tlast, 1'b0);
`endif
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("tready_before_edge", s_axis_tready, 1'b0);
    @(negedge aclk);
    check("tready_after_edge", s_axis_tready, 1'b1);
    q.delete();
  endtask

  initial begin
    #12;
    check("init_s_tready", s_axis_tready, 1'b0);
    check("init_m_tvalid", m_axis_tvalid, 1'b0);
    check("init_m_tdata", m_axis_tdata, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("init_tready_before_edge", s_axis_tready, 1'b0);
    @(negedge aclk);
    check("init_tready_after_edge", s_axis_tready, 1'b1);

    // plain genesis
    send_header(1'b0, 1'b0, 20);
    recv_digest(1'b0, 1'b1, lat_gen);
    check("latency_range", (lat_gen >= 192 && lat_gen <= 200), 1'b1);

    // input gaps and output back-pressure
    send_header(1'b0, 1'b1, 20);
    recv_digest(1'b1, 1'b1, lat_tmp);
    check("latency_stalled", lat_tmp, lat_gen);

    // back-to-back headers; receiver ready again the cycle after the last output
    send_header(1'b0, 1'b0, 20);
    recv_digest(1'b0, 1'b1, lat_tmp);
    @(negedge aclk);
    check("ready_after_send", s_axis_tready, 1'b1);
    send_header(1'b0, 1'b0, 20);
    recv_digest(1'b0, 1'b1, lat_tmp);

    // reset mid-receive
    send_header(1'b0, 1'b0, 10);
    do_reset();
    send_header(1'b0, 1'b0, 20);
    recv_digest(1'b0, 1'b1, lat_tmp);

    // reset mid-hash
    send_header(1'b0, 1'b0, 20);
    repeat (60) @(negedge aclk);
    do_reset();

    // reset mid-send
    send_header(1'b0, 1'b0, 20);
    begin
      int unsigned g = 0;
      while (!m_axis_tvalid && g < 400) begin
        @(negedge aclk);
        g++;
      end
    end
    check("send_reached", m_axis_tvalid, 1'b1);
    do_reset();
    send_header(1'b0, 1'b0, 20);
    recv_digest(1'b1, 1'b1, lat_tmp);

    // all-zero header: latency only
    send_header(1'b1, 1'b0, 20);
    recv_digest(1'b0, 1'b0, lat_zero);
    check("latency_zero_hdr", lat_zero, lat_gen);
    check("queue_empty", q.size(), 0);

    send_header(1'b0, 1'b0, 20);
    recv_digest(1'b0, 1'b1, lat_tmp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
